// File: rtl/enc_pulse_gen.sv
// enc_pulse_gen: encoder A pulse train with Z index every Z_DIV A edges; define ENC_GEN_JITTER_EN for LFSR-randomised low phases
module enc_pulse_gen #(
  parameter int CNT_WIDTH = 32,
  parameter int Z_DIV = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 I_START,
  input  logic                 I_STOP,
  input  logic [CNT_WIDTH-1:0] I_PERIOD,
  input  logic [CNT_WIDTH-1:0] I_WIDTH,
  input  logic [CNT_WIDTH-1:0] I_COUNT,
  output logic                 O_A,
  output logic                 O_Z,
  output logic                 O_BUSY,
  output logic                 O_DONE,
  output logic [CNT_WIDTH-1:0] O_PULSE_CNT
);
  localparam int ZW = Z_DIV > 1 ? $clog2(Z_DIV + 1) : 1;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH:0] tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0] w_q, w_d, l_q, l_d, n_q, n_d, pcnt_q, pcnt_d, pcnt_b, w_eff;
  logic [ZW-1:0] zc_q, zc_d, zc_b;
  logic zp_q, zp_d, z_q, z_d, a_q, busy_q, done_q, rise;
  logic [2:0] jit;
`ifdef ENC_GEN_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign jit = lfsr_q[2:0];
  assign lfsr_d = rise ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  // jitter source steps once per A pulse and reseeds only on reset
  always_ff @(posedge CLK) lfsr_q <= RST ? 16'hACE1 : lfsr_d;
`else
  assign jit = 3'd0;
`endif
  // phase sequencing; the timer counts down the remaining cycles of the current phase
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    w_d = w_q;
    l_d = l_q;
    n_d = n_q;
    pcnt_b = pcnt_q;
    zc_b = zc_q;
    zp_d = 1'b0;
    z_d = zp_q;
    rise = 1'b0;
    w_eff = I_WIDTH == '0 ? CNT_WIDTH'(1) : I_WIDTH;
    if ((state_q == HIGH || state_q == LOW) && I_STOP) begin
      state_d = FINISH;
      z_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (I_START && !I_STOP) begin
          state_d = HIGH;
          rise = 1'b1;
          w_d = w_eff;
          l_d = I_PERIOD > w_eff ? I_PERIOD - w_eff : CNT_WIDTH'(1);
          n_d = I_COUNT;
          tmr_d = {1'b0, w_eff} - 1'b1;
          pcnt_b = '0;
          zc_b = '0;
        end
        HIGH: if (tmr_q == '0) begin
          state_d = LOW;
          tmr_d = {1'b0, l_q} - 1'b1 + (CNT_WIDTH + 1)'(jit);
        end else tmr_d = tmr_q - 1'b1;
        LOW: if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else if (n_q != '0 && pcnt_q == n_q) state_d = FINISH;
        else begin
          state_d = HIGH;
          rise = 1'b1;
          tmr_d = {1'b0, w_q} - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    pcnt_d = rise && !(&pcnt_b) ? pcnt_b + 1'b1 : pcnt_b;
    zc_d = zc_b;
    if (rise && Z_DIV != 0) begin
      zc_d = zc_b == ZW'(Z_DIV - 1) ? '0 : zc_b + 1'b1;
      zp_d = zc_b == ZW'(Z_DIV - 1);
    end
  end
  // state and counters; A/BUSY/DONE are flopped from the next state so they align with it
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tmr_q <= '0;
      w_q <= '0;
      l_q <= '0;
      n_q <= '0;
      pcnt_q <= '0;
      zc_q <= '0;
      zp_q <= 1'b0;
      z_q <= 1'b0;
      a_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      w_q <= w_d;
      l_q <= l_d;
      n_q <= n_d;
      pcnt_q <= pcnt_d;
      zc_q <= zc_d;
      zp_q <= zp_d;
      z_q <= z_d;
      a_q <= state_d == HIGH;
      busy_q <= state_d == HIGH || state_d == LOW;
      done_q <= state_d == FINISH;
    end
  end
  assign O_A = a_q;
  assign O_Z = z_q;
  assign O_BUSY = busy_q;
  assign O_DONE = done_q;
  assign O_PULSE_CNT = pcnt_q;
endmodule

// File: tb/tb_enc_pulse_gen.sv
// tb_enc_pulse_gen: directed and randomized pulse trains checked against an arithmetic timing model
module tb_enc_pulse_gen;
  localparam int CW = 8;
  localparam int ZD = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [CW-1:0] per = '0, wid = '0, cnt = '0, pc;
  logic a, z, busy, done;
  int total = 0, bad = 0, cur_t = 0;

  enc_pulse_gen #(.CNT_WIDTH(CW), .Z_DIV(ZD)) dut (
    .CLK(clk), .RST(rst), .I_START(start), .I_STOP(stop),
    .I_PERIOD(per), .I_WIDTH(wid), .I_COUNT(cnt),
    .O_A(a), .O_Z(z), .O_BUSY(busy), .O_DONE(done), .O_PULSE_CNT(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cur_t, obs, exp);
    end
  endtask

  task automatic chk_idle(input int epc);
    chk("idle_a", a, 0);
    chk("idle_z", z, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_cnt", pc, epc);
  endtask

`ifndef ENC_GEN_JITTER_EN
  function automatic int sat(input int x);
    return x > (1 << CW) - 1 ? (1 << CW) - 1 : x;
  endfunction

  // cycle t after the start edge: pulse k begins at 1+k*(W+L); stop sampled on edge s ends the train
  task automatic check_cycle(input int t, input int w, input int l, input int n, input int s);
    int p, k, ph, ea, ez, eb, ed, ep;
    p = w + l;
    if (s > 0 && t > s) begin
      ea = 0; ez = 0; eb = 0; ed = int'(t == s + 1); ep = sat((s - 1) / p + 1);
    end else if (n != 0 && t >= 1 + n * p) begin
      ea = 0; ez = 0; eb = 0; ed = int'(t == 1 + n * p); ep = n;
    end else begin
      k = (t - 1) / p;
      ph = (t - 1) % p;
      ea = int'(ph < w); ez = int'(ph == 1 && (k + 1) % ZD == 0); eb = 1; ed = 0; ep = sat(k + 1);
    end
    cur_t = t;
    chk("a", a, ea);
    chk("z", z, ez);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("pulse_cnt", pc, ep);
  endtask

  task automatic train(input int p, input int w, input int n, input int s, input bit noise);
    int we, le, tend;
    we = w == 0 ? 1 : w;
    le = p > we ? p - we : 1;
    tend = s > 0 ? s + 1 : 1 + n * (we + le);
    per = CW'(p); wid = CW'(w); cnt = CW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= tend + 1; t++) begin
      check_cycle(t, we, le, n, s);
      if (t <= tend) begin
        stop = t == s;
        if (noise && t < tend) begin
          start = 1'($urandom_range(0, 1));
          per = CW'($urandom); wid = CW'($urandom); cnt = CW'($urandom);
        end else start = 1'b0;
        @(posedge clk); #1;
      end
    end
    stop = 1'b0;
    start = 1'b0;
  endtask
`else
  task automatic rec(output int r[6], output int zt[2]);
    int nr, nz;
    bit prev, fin;
    nr = 0; nz = 0; prev = 1'b0; fin = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    per = 8'd10; wid = 8'd2; cnt = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 300 && !fin; t++) begin
      cur_t = t;
      if (a && !prev) begin
        if (nr < 6) r[nr] = t;
        nr++;
      end
      if (z) begin
        if (nz < 2) zt[nz] = t;
        nz++;
      end
      prev = a;
      if (done) fin = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("j_done_seen", 32'(fin), 1);
    chk("j_rises", nr, 6);
    chk("j_zs", nz, 2);
    chk("j_cnt", pc, 6);
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle(0);
    rst = 1'b0;
`ifdef ENC_GEN_JITTER_EN
    begin
      int r1[6], r2[6], z1[2], z2[2];
      rec(r1, z1);
      rec(r2, z2);
      for (int i = 0; i < 6; i++) chk("j_repeat", r2[i], r1[i]);
      for (int i = 0; i < 5; i++) chk("j_spacing_ok", 32'(r1[i + 1] - r1[i] >= 10 && r1[i + 1] - r1[i] <= 17), 1);
      chk("j_z0", z1[0], r1[2] + 1);
      chk("j_z1", z1[1], r1[5] + 1);
    end
`else
    train(10, 2, 6, 0, 1'b0);
    train(0, 0, 4, 0, 1'b0);
    train(8, 3, 0, 20, 1'b0);
    train(10, 2, 6, 0, 1'b1);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      chk_idle(6);
      @(posedge clk); #1;
    end
    stop = 1'b0;
    chk_idle(6);
    per = 8'd10; wid = 8'd2; cnt = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      check_cycle(t, 2, 8, 6, 0);
      rst = t == 15;
      @(posedge clk); #1;
    end
    cur_t = 16;
    rst = 1'b0;
    repeat (3) begin
      chk_idle(0);
      @(posedge clk); #1;
    end
    train(10, 2, 6, 0, 1'b0);
    train(0, 0, 0, 600, 1'b0);
    repeat (10) begin
      int p, w, n, s, we, le;
      p = $urandom_range(0, 12);
      w = $urandom_range(0, 6);
      n = $urandom_range(0, 5);
      we = w == 0 ? 1 : w;
      le = p > we ? p - we : 1;
      s = n == 0 ? $urandom_range(1, 40) : ($urandom_range(0, 1) != 0 ? $urandom_range(1, n * (we + le)) : 0);
      train(p, w, n, s, 1'($urandom_range(0, 1)));
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
